axi_lite_arbiter: RTL and testbench

AXI_LITE_ARBITER -- requirements
Module: axi_lite_arbiter

---
 rtl/axi_lite_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_axi_lite_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_arbiter.sv
// Two-requester AXI4-Lite arbiter. At most one transaction is outstanding on
// the shared master port, and the two requesters are served in round-robin order.
module axi_lite_arbiter #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic                          aclk,
  input  logic                          areset,
  // requester 0
  input  logic [AXI_ADDR_WIDTH-1:0]     s0_axi_awaddr,
  input  logic                          s0_axi_awvalid,
  output logic                          s0_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]     s0_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   s0_axi_wstrb,
  input  logic                          s0_axi_wvalid,
  output logic                          s0_axi_wready,
  output logic [1:0]                    s0_axi_bresp,
  output logic                          s0_axi_bvalid,
  input  logic                          s0_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]     s0_axi_araddr,
  input  logic                          s0_axi_arvalid,
  output logic                          s0_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0]     s0_axi_rdata,
  output logic [1:0]                    s0_axi_rresp,
  output logic                          s0_axi_rvalid,
  input  logic                          s0_axi_rready,
  // requester 1
  input  logic [AXI_ADDR_WIDTH-1:0]     s1_axi_awaddr,
  input  logic                          s1_axi_awvalid,
  output logic                          s1_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]     s1_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   s1_axi_wstrb,
  input  logic                          s1_axi_wvalid,
  output logic                          s1_axi_wready,
  output logic [1:0]                    s1_axi_bresp,
  output logic                          s1_axi_bvalid,
  input  logic                          s1_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]     s1_axi_araddr,
  input  logic                          s1_axi_arvalid,
  output logic                          s1_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0]     s1_axi_rdata,
  output logic [1:0]                    s1_axi_rresp,
  output logic                          s1_axi_rvalid,
  input  logic                          s1_axi_rready,
  // shared downstream port
  output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  output logic [AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA
  } state_t;

  state_t state_q, state_d;
  logic   grant_q, grant_d;   // 0 = requester 0, 1 = requester 1
  logic   rr_q, rr_d;         // requester that has priority in IDLE
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;

  logic req0, req1, pick, pick_aw;
  logic sel_awvalid, sel_wvalid, sel_bready, sel_arvalid, sel_rready;
  logic [AXI_ADDR_WIDTH-1:0]   sel_awaddr, sel_araddr;
  logic [AXI_DATA_WIDTH-1:0]   sel_wdata;
  logic [AXI_DATA_WIDTH/8-1:0] sel_wstrb;
  logic in_wad, in_wresp, in_rad, in_rdd, active;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      rr_q      <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Requester-side selection driven only by the registered grant.
  assign sel_awvalid = grant_q ? s1_axi_awvalid : s0_axi_awvalid;
  assign sel_wvalid  = grant_q ? s1_axi_wvalid  : s0_axi_wvalid;
  assign sel_bready  = grant_q ? s1_axi_bready  : s0_axi_bready;
  assign sel_arvalid = grant_q ? s1_axi_arvalid : s0_axi_arvalid;
  assign sel_rready  = grant_q ? s1_axi_rready  : s0_axi_rready;
  assign sel_awaddr  = grant_q ? s1_axi_awaddr  : s0_axi_awaddr;
  assign sel_araddr  = grant_q ? s1_axi_araddr  : s0_axi_araddr;
  assign sel_wdata   = grant_q ? s1_axi_wdata   : s0_axi_wdata;
  assign sel_wstrb   = grant_q ? s1_axi_wstrb   : s0_axi_wstrb;

  assign in_wad   = (state_q == WR_ADDR_DATA);
  assign in_wresp = (state_q == WR_RESP);
  assign in_rad   = (state_q == RD_ADDR);
  assign in_rdd   = (state_q == RD_DATA);
  assign active   = (state_q != IDLE);

  assign m_axi_awvalid = in_wad & sel_awvalid & ~aw_done_q;
  assign m_axi_wvalid  = in_wad & sel_wvalid & ~w_done_q;
  assign m_axi_bready  = in_wresp & sel_bready;
  assign m_axi_arvalid = in_rad & sel_arvalid;
  assign m_axi_rready  = in_rdd & sel_rready;
  assign m_axi_awaddr  = active ? sel_awaddr : '0;
  assign m_axi_araddr  = active ? sel_araddr : '0;
  assign m_axi_wdata   = active ? sel_wdata  : '0;
  assign m_axi_wstrb   = active ? sel_wstrb  : '0;

  assign aw_hs = m_axi_awvalid & m_axi_awready;
  assign w_hs  = m_axi_wvalid & m_axi_wready;
  assign b_hs  = m_axi_bvalid & m_axi_bready;
  assign ar_hs = m_axi_arvalid & m_axi_arready;
  assign r_hs  = m_axi_rvalid & m_axi_rready;

  assign req0 = s0_axi_awvalid | s0_axi_arvalid;
  assign req1 = s1_axi_awvalid | s1_axi_arvalid;
  assign pick    = rr_q ? req1 : ~req0;
  assign pick_aw = pick ? s1_axi_awvalid : s0_axi_awvalid;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          grant_d   = pick;
          state_d   = pick_aw ? WR_ADDR_DATA : RD_ADDR;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WR_ADDR_DATA: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (b_hs) begin
          state_d = IDLE;
          rr_d    = ~grant_q;
        end
      end
      RD_ADDR: begin
        if (ar_hs) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (r_hs) begin
          state_d = IDLE;
          rr_d    = ~grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Return paths: only the granted port sees readies/valids; the other is held quiet.
  assign s0_axi_awready = in_wad & ~grant_q & ~aw_done_q & m_axi_awready;
  assign s0_axi_wready  = in_wad & ~grant_q & ~w_done_q & m_axi_wready;
  assign s0_axi_bvalid  = in_wresp & ~grant_q & m_axi_bvalid;
  assign s0_axi_bresp   = (in_wresp & ~grant_q) ? m_axi_bresp : 2'b00;
  assign s0_axi_arready = in_rad & ~grant_q & m_axi_arready;
  assign s0_axi_rvalid  = in_rdd & ~grant_q & m_axi_rvalid;
  assign s0_axi_rdata   = (in_rdd & ~grant_q) ? m_axi_rdata : '0;
  assign s0_axi_rresp   = (in_rdd & ~grant_q) ? m_axi_rresp : 2'b00;

  assign s1_axi_awready = in_wad & grant_q & ~aw_done_q & m_axi_awready;
  assign s1_axi_wready  = in_wad & grant_q & ~w_done_q & m_axi_wready;
  assign s1_axi_bvalid  = in_wresp & grant_q & m_axi_bvalid;
  assign s1_axi_bresp   = (in_wresp & grant_q) ? m_axi_bresp : 2'b00;
  assign s1_axi_arready = in_rad & grant_q & m_axi_arready;
  assign s1_axi_rvalid  = in_rdd & grant_q & m_axi_rvalid;
  assign s1_axi_rdata   = (in_rdd & grant_q) ? m_axi_rdata : '0;
  assign s1_axi_rresp   = (in_rdd & grant_q) ? m_axi_rresp : 2'b00;

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Scoreboard bench for axi_lite_arbiter: expected transfers are queued at issue
// time and a negedge monitor pops and compares them as handshakes occur.
module tb_axi_lite_arbiter;
  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  logic [31:0] s_awaddr [2];
  logic [31:0] s_wdata [2];
  logic [31:0] s_araddr [2];
  logic [31:0] s_rdata [2];
  logic [3:0]  s_wstrb [2];
  logic [1:0]  s_bresp [2];
  logic [1:0]  s_rresp [2];
  logic s_awvalid [2];
  logic s_awready [2];
  logic s_wvalid [2];
  logic s_wready [2];
  logic s_bvalid [2];
  logic s_bready [2];
  logic s_arvalid [2];
  logic s_arready [2];
  logic s_rvalid [2];
  logic s_rready [2];

  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;
  logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic m_arvalid, m_arready, m_rvalid, m_rready;

  axi_lite_arbiter #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32)) dut (
    .aclk(aclk), .areset(areset),
    .s0_axi_awaddr(s_awaddr[0]), .s0_axi_awvalid(s_awvalid[0]), .s0_axi_awready(s_awready[0]),
    .s0_axi_wdata(s_wdata[0]), .s0_axi_wstrb(s_wstrb[0]), .s0_axi_wvalid(s_wvalid[0]),
    .s0_axi_wready(s_wready[0]), .s0_axi_bresp(s_bresp[0]), .s0_axi_bvalid(s_bvalid[0]),
    .s0_axi_bready(s_bready[0]), .s0_axi_araddr(s_araddr[0]), .s0_axi_arvalid(s_arvalid[0]),
    .s0_axi_arready(s_arready[0]), .s0_axi_rdata(s_rdata[0]), .s0_axi_rresp(s_rresp[0]),
    .s0_axi_rvalid(s_rvalid[0]), .s0_axi_rready(s_rready[0]),
    .s1_axi_awaddr(s_awaddr[1]), .s1_axi_awvalid(s_awvalid[1]), .s1_axi_awready(s_awready[1]),
    .s1_axi_wdata(s_wdata[1]), .s1_axi_wstrb(s_wstrb[1]), .s1_axi_wvalid(s_wvalid[1]),
    .s1_axi_wready(s_wready[1]), .s1_axi_bresp(s_bresp[1]), .s1_axi_bvalid(s_bvalid[1]),
    .s1_axi_bready(s_bready[1]), .s1_axi_araddr(s_araddr[1]), .s1_axi_arvalid(s_arvalid[1]),
    .s1_axi_arready(s_arready[1]), .s1_axi_rdata(s_rdata[1]), .s1_axi_rresp(s_rresp[1]),
    .s1_axi_rvalid(s_rvalid[1]), .s1_axi_rready(s_rready[1]),
    .m_axi_awaddr(m_awaddr), .m_axi_awvalid(m_awvalid), .m_axi_awready(m_awready),
    .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb), .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready),
    .m_axi_bresp(m_bresp), .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready),
    .m_axi_araddr(m_araddr), .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready),
    .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp), .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rdf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  typedef struct { bit wr; logic [31:0] addr; } addr_t;
  typedef struct { logic [31:0] d; logic [3:0] s; } w_t;
  typedef struct { int p; bit rd; logic [31:0] d; logic [1:0] r; } rsp_t;
  addr_t addr_q[$];
  w_t    w_q[$];
  rsp_t  rsp_q[$];

  task automatic exp_wr(input int p, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [1:0] br);
    addr_q.push_back('{1'b1, a});
    w_q.push_back('{d, s});
    rsp_q.push_back('{p, 1'b0, 32'h0, br});
  endtask

  task automatic exp_rd(input int p, input logic [31:0] a);
    logic [1:0] rr;
    rr = a[5:4];
    addr_q.push_back('{1'b0, a});
    rsp_q.push_back('{p, 1'b1, rdf(a), rr});
  endtask

  // ---------------- downstream slave model ----------------
  int aw_delay = 0;
  logic [1:0] bresp_cfg = 2'b00;
  bit slv_flush = 1'b0;

  initial begin
    int aw_wait;
    bit got_aw, got_w, awhs, whs, bhs, arhs, rhs, awpend, fl;
    logic [31:0] ar_a;
    aw_wait = 0; got_aw = 0; got_w = 0;
    m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
    m_bvalid = 1'b0; m_bresp = 2'b00; m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00;
    forever begin
      @(negedge aclk);
      fl = slv_flush;
      awhs = m_awvalid && m_awready;
      whs  = m_wvalid && m_wready;
      bhs  = m_bvalid && m_bready;
      arhs = m_arvalid && m_arready;
      rhs  = m_rvalid && m_rready;
      awpend = m_awvalid && !m_awready;
      ar_a = m_araddr;
      @(posedge aclk);
      #1;
      if (fl) begin
        m_bvalid = 1'b0; m_rvalid = 1'b0; got_aw = 0; got_w = 0; aw_wait = 0;
      end else begin
        if (awhs) begin got_aw = 1; aw_wait = 0; end
        else if (awpend) aw_wait++;
        if (whs) got_w = 1;
        if (bhs) m_bvalid = 1'b0;
        if (got_aw && got_w && !m_bvalid) begin
          m_bvalid = 1'b1; m_bresp = bresp_cfg; got_aw = 0; got_w = 0;
        end
        if (rhs) m_rvalid = 1'b0;
        if (arhs) begin m_rvalid = 1'b1; m_rdata = rdf(ar_a); m_rresp = ar_a[5:4]; end
      end
      m_awready = (aw_wait >= aw_delay);
      m_wready  = 1'b1;
      m_arready = 1'b1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int n_aw = 0, n_w = 0, last_aw_cyc = 0;
  initial begin
    addr_t ea; w_t ew; rsp_t er;
    forever begin
      @(negedge aclk);
      if (m_awvalid && m_awready) begin
        n_aw++; last_aw_cyc = cyc;
        if (addr_q.size() == 0) chk("aw_unexpected", 64'(addr_q.size()), 1);
        else begin
          ea = addr_q.pop_front();
          $display("AW  addr=%08h wr_exp=%0d", m_awaddr, ea.wr);
          chk("aw_kind", 1, 64'(ea.wr)); chk("awaddr", m_awaddr, ea.addr);
        end
      end
      if (m_wvalid && m_wready) begin
        n_w++;
        if (w_q.size() == 0) chk("w_unexpected", 64'(w_q.size()), 1);
        else begin
          ew = w_q.pop_front();
          $display("W   data=%08h strb=%h", m_wdata, m_wstrb);
          chk("wdata", m_wdata, ew.d); chk("wstrb", m_wstrb, ew.s);
        end
      end
      if (m_arvalid && m_arready) begin
        if (addr_q.size() == 0) chk("ar_unexpected", 64'(addr_q.size()), 1);
        else begin
          ea = addr_q.pop_front();
          $display("AR  addr=%08h", m_araddr);
          chk("ar_kind", 0, 64'(ea.wr)); chk("araddr", m_araddr, ea.addr);
        end
      end
      for (int p = 0; p < 2; p++) begin
        if ((s_bvalid[p] && s_bready[p]) || (s_rvalid[p] && s_rready[p])) begin
          if (rsp_q.size() == 0) chk("rsp_unexpected", 64'(rsp_q.size()), 1);
          else begin
            er = rsp_q.pop_front();
            chk("rsp_port", 64'(p), 64'(er.p));
            if (s_bvalid[p]) begin
              $display("B   port=%0d bresp=%0d", p, s_bresp[p]);
              chk("rsp_kind_b", 0, 64'(er.rd)); chk("bresp", s_bresp[p], er.r);
            end else begin
              $display("R   port=%0d data=%08h rresp=%0d", p, s_rdata[p], s_rresp[p]);
              chk("rsp_kind_r", 1, 64'(er.rd)); chk("rdata", s_rdata[p], er.d);
              chk("rresp", s_rresp[p], er.r);
            end
          end
        end
      end
    end
  end

  // ---------------- requester tasks (entered just after a rising edge) ----------------
  int issue_cyc = 0;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic wr(input int p, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, input int w_lead);
    bit aw_ok, w_ok, b_ok;
    int t;
    aw_ok = 0; w_ok = 0; b_ok = 0; t = 0;
    s_wvalid[p] = 1'b1; s_wdata[p] = d; s_wstrb[p] = s; s_bready[p] = 1'b1;
    repeat (w_lead) step();
    s_awvalid[p] = 1'b1; s_awaddr[p] = a; issue_cyc = cyc;
    while (!b_ok && t < 200) begin
      @(negedge aclk);
      if (s_awvalid[p] && s_awready[p]) aw_ok = 1;
      if (s_wvalid[p] && s_wready[p]) w_ok = 1;
      if (s_bvalid[p] && s_bready[p]) b_ok = 1;
      step();
      if (aw_ok) s_awvalid[p] = 1'b0;
      if (w_ok) s_wvalid[p] = 1'b0;
      t++;
    end
    s_awvalid[p] = 1'b0; s_wvalid[p] = 1'b0; s_bready[p] = 1'b0;
    chk("wr_complete", 64'(b_ok), 1);
  endtask

  task automatic rd(input int p, input logic [31:0] a);
    bit ar_ok, r_ok;
    int t;
    ar_ok = 0; r_ok = 0; t = 0;
    s_arvalid[p] = 1'b1; s_araddr[p] = a; s_rready[p] = 1'b1;
    while (!r_ok && t < 200) begin
      @(negedge aclk);
      ar_ok = s_arvalid[p] && s_arready[p];
      r_ok  = s_rvalid[p] && s_rready[p];
      step();
      if (ar_ok) s_arvalid[p] = 1'b0;
      t++;
    end
    s_arvalid[p] = 1'b0; s_rready[p] = 1'b0;
    chk("rd_complete", 64'(r_ok), 1);
  endtask

  task automatic do_reset();
    areset = 1'b1;
    repeat (3) step();
    areset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int viol, base_aw, base_w;
    bit seen;
    for (int p = 0; p < 2; p++) begin
      s_awaddr[p] = '0; s_wdata[p] = '0; s_araddr[p] = '0; s_wstrb[p] = '0;
      s_awvalid[p] = 1'b0; s_wvalid[p] = 1'b0; s_bready[p] = 1'b0;
      s_arvalid[p] = 1'b0; s_rready[p] = 1'b0;
    end
    do_reset();

    // reset state
    @(negedge aclk);
    chk("rst_m_ctrl", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 0);
    chk("rst_m_payload", m_awaddr | m_araddr | m_wdata | 32'(m_wstrb), 0);
    chk("rst_s0_ctrl", {s_awready[0], s_wready[0], s_arready[0], s_bvalid[0], s_rvalid[0]}, 0);
    chk("rst_s1_ctrl", {s_awready[1], s_wready[1], s_arready[1], s_bvalid[1], s_rvalid[1]}, 0);
    step();

    // single write from s0, slave ready immediately
    exp_wr(0, 32'h04, 32'h3344_5566, 4'hF, 2'b00);
    wr(0, 32'h04, 32'h3344_5566, 4'hF, 0);
    chk("aw_latency", 64'(last_aw_cyc - issue_cyc), 1);
    @(negedge aclk);
    chk("idle_after_wr", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 0);
    step();

    // simultaneous reads after reset: s0 first, s1 held off
    do_reset();
    exp_rd(0, 32'h04);
    exp_rd(1, 32'h60);
    viol = 0;
    fork
      rd(0, 32'h04);
      rd(1, 32'h60);
      begin
        for (int t = 0; t < 200; t++) begin
          @(negedge aclk);
          if (s_arready[1]) viol++;
          if (s_rvalid[0] && s_rready[0]) break;
        end
      end
    join
    chk("s1_arready_before_s0_r", 64'(viol), 0);

    // back-to-back s0 writes against a pending s1 read: s0, s1, s0, s0
    exp_wr(0, 32'h10, 32'h1111_0001, 4'hF, 2'b00);
    exp_rd(1, 32'h20);
    exp_wr(0, 32'h14, 32'h1111_0002, 4'hF, 2'b00);
    exp_wr(0, 32'h18, 32'h1111_0003, 4'hF, 2'b00);
    fork
      begin
        wr(0, 32'h10, 32'h1111_0001, 4'hF, 0);
        wr(0, 32'h14, 32'h1111_0002, 4'hF, 0);
        wr(0, 32'h18, 32'h1111_0003, 4'hF, 0);
      end
      rd(1, 32'h20);
    join

    // s1: W leads AW by 3 cycles, slave awready delayed 2 cycles
    aw_delay = 2;
    base_aw = n_aw; base_w = n_w; viol = 0;
    exp_wr(1, 32'h30, 32'hA1B2_C3D4, 4'b0011, 2'b00);
    fork
      wr(1, 32'h30, 32'hA1B2_C3D4, 4'b0011, 3);
      begin
        for (int t = 0; t < 200; t++) begin
          @(negedge aclk);
          if (m_bready && (n_aw == base_aw || n_w == base_w)) viol++;
          if (s_bvalid[1] && s_bready[1]) break;
        end
      end
    join
    chk("aw_hs_count", 64'(n_aw - base_aw), 1);
    chk("w_hs_count", 64'(n_w - base_w), 1);
    chk("wresp_before_both_hs", 64'(viol), 0);
    aw_delay = 0;

    // slave error response to s1 must not leak to s0
    bresp_cfg = 2'b10;
    viol = 0;
    exp_wr(1, 32'h40, 32'h5A5A_0F0F, 4'hC, 2'b10);
    fork
      wr(1, 32'h40, 32'h5A5A_0F0F, 4'hC, 0);
      begin
        for (int t = 0; t < 200; t++) begin
          @(negedge aclk);
          if (s_bvalid[0] || s_bresp[0] != 2'b00) viol++;
          if (s_bvalid[1] && s_bready[1]) break;
        end
      end
    join
    chk("s0_bresp_quiet", 64'(viol), 0);
    bresp_cfg = 2'b00;

    // reset in RD_DATA with rvalid high and rready low
    addr_q.push_back('{1'b0, 32'h04});
    s_arvalid[0] = 1'b1; s_araddr[0] = 32'h04; s_rready[0] = 1'b0;
    seen = 0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge aclk);
      seen = s_arvalid[0] && s_arready[0];
      step();
    end
    s_arvalid[0] = 1'b0;
    seen = 0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge aclk);
      seen = s_rvalid[0] && m_rvalid && !m_rready;
      step();
    end
    chk("rd_data_stalled", 64'(seen), 1);
    areset = 1'b1;
    step();
    areset = 1'b0;
    @(negedge aclk);
    chk("post_rst_rvalid", {s_rvalid[0], s_rvalid[1], m_rready, m_arvalid}, 0);
    chk("post_rst_rdata", s_rdata[0], 0);
    step();
    slv_flush = 1'b1;
    step();
    slv_flush = 1'b0;
    step();
    exp_rd(1, 32'h60);
    rd(1, 32'h60);

    repeat (3) step();
    chk("addr_q_empty", 64'(addr_q.size()), 0);
    chk("w_q_empty", 64'(w_q.size()), 0);
    chk("rsp_q_empty", 64'(rsp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
